// File: rtl/mcu_el2_lsu_trigger_cnt_pkg.sv
// Shared types and helpers for the LSU debug-trigger unit.
// Holds the per-channel trigger configuration packet, the LSU M-stage
// packet and the exact / NAPOT mask-and-match compare helper.
package mcu_el2_lsu_trigger_cnt_pkg;

    // Compare width carried by the configuration packet (tdata2).
    localparam int LSU_TRIG_DW = 32;

    // LSU M-stage access descriptor.
    typedef struct packed {
        logic valid;
        logic load;
        logic store;
        logic dma;
        logic by;
        logic half;
        logic word;
    } mcu_el2_lsu_pkt_t;

    // Per-channel trigger configuration as written by dec.
    typedef struct packed {
        logic                   m;
        logic                   select;
        logic                   load;
        logic                   store;
        logic                   match;
        logic                   chain;
        logic [LSU_TRIG_DW-1:0] tdata2;
    } mcu_el2_lsu_trig_cfg_t;

    // NAPOT don't-care mask: bit i is set while tdata2[i:0] is all ones,
    // so only the trailing run of ones is excluded from the compare.
    function automatic logic [LSU_TRIG_DW-1:0] trig_napot_dc_mask(
        input logic [LSU_TRIG_DW-1:0] tdata2
    );
        logic [LSU_TRIG_DW-1:0] dc_v;
        logic                   run_v;
        dc_v  = {LSU_TRIG_DW{1'b0}};
        run_v = 1'b1;
        for (int i = 0; i < LSU_TRIG_DW; i++) begin
            run_v   = run_v & tdata2[i];
            dc_v[i] = run_v;
        end
        return dc_v;
    endfunction

    // Mask-and-match compare: exact when napot=0, trailing ones ignored when napot=1.
    function automatic logic trig_maskandmatch(
        input logic [LSU_TRIG_DW-1:0] tdata2,
        input logic [LSU_TRIG_DW-1:0] operand,
        input logic                   napot
    );
        logic [LSU_TRIG_DW-1:0] dc_v;
        dc_v = napot ? trig_napot_dc_mask(tdata2) : {LSU_TRIG_DW{1'b0}};
        return &((tdata2 ~^ operand) | dc_v);
    endfunction

endpackage

// File: rtl/mcu_el2_lsu_trigger_cnt_chan.sv
// One trigger channel: hit counter with auto-reload, registered fire pulse
// and sticky hit status. A counter value of 0 or 1 fires on the next match.
module mcu_el2_lsu_trigger_cnt_chan
    import mcu_el2_lsu_trigger_cnt_pkg::*;
#(
    parameter int CW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          eff_i,
    input  logic          cnt_ld_i,
    input  logic [CW-1:0] cnt_val_i,
    input  logic          hit_clr_i,
    output logic          match_r_o,
    output logic          hit_o,
    output logic [CW-1:0] cnt_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          fire_s;
    logic          match_q;
    logic          hit_q;
    logic          hit_d;

    // Counter next state and fire decision; a dec reload beats a match.
    always_comb begin
        cnt_d  = cnt_q;
        fire_s = 1'b0;
        if (cnt_ld_i) begin
            cnt_d  = cnt_val_i;
            fire_s = 1'b0;
        end else if (eff_i) begin
            if (cnt_q <= CW'(1)) begin
                fire_s = 1'b1;
                cnt_d  = cnt_val_i;
            end else begin
                fire_s = 1'b0;
                cnt_d  = cnt_q - CW'(1);
            end
        end else begin
            cnt_d  = cnt_q;
            fire_s = 1'b0;
        end
    end

    // Sticky hit: a new fire takes priority over a clear in the same cycle.
    always_comb begin
        hit_d = fire_s | (hit_q & ~hit_clr_i);
    end

    // State registers; reset discards any pending fire and zeroes the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= {CW{1'b0}};
            match_q <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            match_q <= fire_s;
            hit_q   <= hit_d;
        end
    end

    assign match_r_o = match_q;
    assign hit_o     = hit_q;
    assign cnt_o     = cnt_q;

endmodule

// File: rtl/mcu_el2_lsu_trigger_cnt.sv
// LSU debug-trigger unit: NUM_TRIG channels compare the M-stage address or
// size-gated store data against tdata2 (exact or NAPOT), optionally chain
// even/odd pairs, count hits and present registered fire pulses in R stage.
// Optional feature macro: MCU_EL2_LSU_TRIG_CHAIN_EN (pair chaining honoured).
// DW must equal LSU_TRIG_DW, the tdata2 width of the configuration packet.
module mcu_el2_lsu_trigger_cnt
    import mcu_el2_lsu_trigger_cnt_pkg::*;
#(
    parameter int NUM_TRIG = 4,
    parameter int DW       = LSU_TRIG_DW,
    parameter int CW       = 14
) (
    input  logic                              clk,
    input  logic                              rst,
    input  mcu_el2_lsu_trig_cfg_t [NUM_TRIG-1:0] trig_cfg,
    input  logic [NUM_TRIG-1:0]               cnt_ld,
    input  logic [NUM_TRIG-1:0][CW-1:0]       cnt_val,
    input  mcu_el2_lsu_pkt_t                  lsu_pkt_m,
    input  logic                              lsu_flush_m,
    input  logic [DW-1:0]                     lsu_addr_m,
    input  logic [DW-1:0]                     store_data_m,
    input  logic [NUM_TRIG-1:0]               hit_clr,
    output logic [NUM_TRIG-1:0]               lsu_trigger_match_r,
    output logic [NUM_TRIG-1:0]               lsu_trigger_hit,
    output logic [NUM_TRIG-1:0][CW-1:0]       trig_cnt
);

    logic [NUM_TRIG-1:0]         m_vec_s;
    logic                        enable_s;
    logic [DW-1:0]               addr_op_s;
    logic [DW-1:0]               data_op_s;
    logic                        acc_ok_s;
    logic [NUM_TRIG-1:0][DW-1:0] op_s;
    logic [NUM_TRIG-1:0]         raw_s;
    logic [NUM_TRIG-1:0]         eff_s;
    logic                        by_unused_s;

    // Byte accesses need no extra gating: the low byte always takes part.
    assign by_unused_s = lsu_pkt_m.by;

    // Global enable and operand gating: operands held at zero while no channel is armed.
    always_comb begin
        m_vec_s = {NUM_TRIG{1'b0}};
        for (int i = 0; i < NUM_TRIG; i++) begin
            m_vec_s[i] = trig_cfg[i].m;
        end
        enable_s  = |m_vec_s;
        addr_op_s = {DW{1'b0}};
        data_op_s = {DW{1'b0}};
        if (enable_s) begin
            addr_op_s       = lsu_addr_m;
            data_op_s[7:0]  = store_data_m[7:0];
            if (lsu_pkt_m.half | lsu_pkt_m.word) begin
                data_op_s[15:8] = store_data_m[15:8];
            end else begin
                data_op_s[15:8] = 8'h00;
            end
            if (lsu_pkt_m.word) begin
                data_op_s[DW-1:16] = store_data_m[DW-1:16];
            end else begin
                data_op_s[DW-1:16] = {(DW-16){1'b0}};
            end
        end else begin
            addr_op_s = {DW{1'b0}};
            data_op_s = {DW{1'b0}};
        end
    end

    // Per-channel raw match: access qualification, type filter and compare.
    always_comb begin
        acc_ok_s = lsu_pkt_m.valid & ~lsu_pkt_m.dma & ~lsu_flush_m & enable_s;
        op_s     = {(NUM_TRIG*DW){1'b0}};
        raw_s    = {NUM_TRIG{1'b0}};
        for (int i = 0; i < NUM_TRIG; i++) begin
            if (trig_cfg[i].select) begin
                op_s[i] = data_op_s;
            end else begin
                op_s[i] = addr_op_s;
            end
            raw_s[i] = acc_ok_s
                     & ((trig_cfg[i].store & lsu_pkt_m.store)
                        | (trig_cfg[i].load & lsu_pkt_m.load & ~trig_cfg[i].select))
                     & trig_maskandmatch(trig_cfg[i].tdata2, op_s[i], trig_cfg[i].match);
        end
    end

`ifdef MCU_EL2_LSU_TRIG_CHAIN_EN
    // Pair chaining: a chained even channel and its odd partner fire only together.
    always_comb begin
        eff_s = raw_s;
        for (int i = 0; i < NUM_TRIG; i += 2) begin
            if (trig_cfg[i].chain) begin
                eff_s[i]   = raw_s[i] & raw_s[i+1];
                eff_s[i+1] = raw_s[i] & raw_s[i+1];
            end else begin
                eff_s[i]   = raw_s[i];
                eff_s[i+1] = raw_s[i+1];
            end
        end
    end
`else
    logic [NUM_TRIG-1:0] chain_unused_s;

    // No chaining built: every channel stands alone and the chain bit is ignored.
    always_comb begin
        eff_s          = raw_s;
        chain_unused_s = {NUM_TRIG{1'b0}};
        for (int i = 0; i < NUM_TRIG; i++) begin
            chain_unused_s[i] = trig_cfg[i].chain;
        end
    end
`endif

    for (genvar g = 0; g < NUM_TRIG; g++) begin : g_chan
        mcu_el2_lsu_trigger_cnt_chan #(
            .CW (CW)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .eff_i     (eff_s[g]),
            .cnt_ld_i  (cnt_ld[g]),
            .cnt_val_i (cnt_val[g]),
            .hit_clr_i (hit_clr[g]),
            .match_r_o (lsu_trigger_match_r[g]),
            .hit_o     (lsu_trigger_hit[g]),
            .cnt_o     (trig_cnt[g])
        );
    end

endmodule

// File: tb/tb_mcu_el2_lsu_trigger_cnt.sv
// Directed scoreboard bench for mcu_el2_lsu_trigger_cnt (4 channels, CW=14).
module tb_mcu_el2_lsu_trigger_cnt;
    import mcu_el2_lsu_trigger_cnt_pkg::*;

    localparam int NT = 4;
    localparam int CW = 14;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                        rst;
    mcu_el2_lsu_trig_cfg_t [NT-1:0] cfg;
    logic [NT-1:0]               cnt_ld;
    logic [NT-1:0][CW-1:0]       cnt_val;
    mcu_el2_lsu_pkt_t            pkt;
    logic                        flush;
    logic [DW-1:0]               addr;
    logic [DW-1:0]               sdata;
    logic [NT-1:0]               hit_clr;
    logic [NT-1:0]               match_r;
    logic [NT-1:0]               hit;
    logic [NT-1:0][CW-1:0]       tcnt;

    mcu_el2_lsu_trigger_cnt #(.NUM_TRIG(NT), .DW(DW), .CW(CW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .trig_cfg            (cfg),
        .cnt_ld              (cnt_ld),
        .cnt_val             (cnt_val),
        .lsu_pkt_m           (pkt),
        .lsu_flush_m         (flush),
        .lsu_addr_m          (addr),
        .store_data_m        (sdata),
        .hit_clr             (hit_clr),
        .lsu_trigger_match_r (match_r),
        .lsu_trigger_hit     (hit),
        .trig_cnt            (tcnt)
    );

    typedef struct packed {
        logic [NT-1:0]         m;
        logic [NT-1:0]         h;
        logic [NT-1:0][CW-1:0] c;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    errors = 0;
    int    checks = 0;

    localparam logic [2:0] SZ_B = 3'b100;
    localparam logic [2:0] SZ_H = 3'b010;
    localparam logic [2:0] SZ_W = 3'b001;

    // Monitor: one cycle after each issued M-stage cycle the R-stage outputs are compared.
    always begin
        exp_t  e;
        string nm;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (match_r !== e.m) begin
                errors++;
                $display("FAIL %s match_r got %b want %b", nm, match_r, e.m);
            end
            checks++;
            if (hit !== e.h) begin
                errors++;
                $display("FAIL %s hit got %b want %b", nm, hit, e.h);
            end
            checks++;
            if (tcnt !== e.c) begin
                errors++;
                $display("FAIL %s trig_cnt got %h want %h", nm, tcnt, e.c);
            end
        end
    end

    function automatic mcu_el2_lsu_trig_cfg_t mk_cfg(input logic m, input logic sel,
                                                     input logic ld, input logic st,
                                                     input logic mt, input logic ch,
                                                     input logic [31:0] td);
        mcu_el2_lsu_trig_cfg_t c;
        c.m      = m;
        c.select = sel;
        c.load   = ld;
        c.store  = st;
        c.match  = mt;
        c.chain  = ch;
        c.tdata2 = td;
        return c;
    endfunction

    task automatic access(input logic ld, input logic st, input logic dma,
                          input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        pkt.valid = 1'b1;
        pkt.load  = ld;
        pkt.store = st;
        pkt.dma   = dma;
        pkt.by    = sz[2];
        pkt.half  = sz[1];
        pkt.word  = sz[0];
        addr      = a;
        sdata     = d;
    endtask

    // Queue the expected R-stage response, clock the M-stage cycle, drop one-shot inputs.
    task automatic cyc(input string nm, input logic [NT-1:0] em, input logic [NT-1:0] eh,
                       input logic [CW-1:0] c0);
        exp_t e;
        e.m    = em;
        e.h    = eh;
        e.c    = '0;
        e.c[0] = c0;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        @(negedge clk);
        pkt     = '0;
        flush   = 1'b0;
        cnt_ld  = '0;
        hit_clr = '0;
        rst     = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst     = 1'b1;
        cfg     = '0;
        cnt_ld  = '0;
        cnt_val = '0;
        pkt     = '0;
        flush   = 1'b0;
        addr    = '0;
        sdata   = '0;
        hit_clr = '0;
        @(negedge clk);
        rst = 1'b1;
        cyc("reset", 4'b0000, 4'b0000, 14'd0);

        // Exact address match on loads
        cfg[0] = mk_cfg(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h8000_1000);
        access(1'b1, 1'b0, 1'b0, SZ_W, 32'h8000_1000, 32'h0);
        cyc("t1_load_hit", 4'b0001, 4'b0001, 14'd0);
        cyc("t1_idle", 4'b0000, 4'b0001, 14'd0);
        access(1'b1, 1'b0, 1'b0, SZ_W, 32'h8000_1004, 32'h0);
        cyc("t1_load_miss", 4'b0000, 4'b0001, 14'd0);

        // NAPOT address match on stores
        cfg[1] = mk_cfg(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h8000_10FF);
        access(1'b0, 1'b1, 1'b0, SZ_W, 32'h8000_1080, 32'h0);
        cyc("t2_napot_in", 4'b0010, 4'b0011, 14'd0);
        access(1'b0, 1'b1, 1'b0, SZ_W, 32'h8000_1100, 32'h0);
        cyc("t2_napot_above", 4'b0000, 4'b0011, 14'd0);
        access(1'b0, 1'b1, 1'b0, SZ_W, 32'h8000_1000, 32'h0);
        cyc("t2_napot_base", 4'b0010, 4'b0011, 14'd0);
        access(1'b0, 1'b1, 1'b0, SZ_W, 32'h8000_0FFF, 32'h0);
        cyc("t2_napot_below", 4'b0000, 4'b0011, 14'd0);

        // Store-data match with size gating
        cfg[2] = mk_cfg(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_00AB);
        access(1'b0, 1'b1, 1'b0, SZ_B, 32'h8000_2000, 32'h1234_56AB);
        cyc("t3_data_byte", 4'b0100, 4'b0111, 14'd0);
        access(1'b1, 1'b0, 1'b0, SZ_W, 32'h8000_2000, 32'h1234_56AB);
        cyc("t3_data_load", 4'b0000, 4'b0111, 14'd0);
        access(1'b0, 1'b1, 1'b0, SZ_W, 32'h8000_2000, 32'h1234_56AB);
        cyc("t3_data_word", 4'b0000, 4'b0111, 14'd0);
        access(1'b0, 1'b1, 1'b0, SZ_H, 32'h8000_2000, 32'hFFFF_00AB);
        cyc("t3_data_half", 4'b0100, 4'b0111, 14'd0);

        // Sticky hit clear, and set beating clear
        hit_clr = 4'b0110;
        cyc("clr_hits", 4'b0000, 4'b0001, 14'd0);
        access(1'b1, 1'b0, 1'b0, SZ_W, 32'h8000_1000, 32'h0);
        hit_clr = 4'b0001;
        cyc("set_wins_clr", 4'b0001, 4'b0001, 14'd0);

        // Hit counting with auto-reload
        cnt_val[0] = 14'd3;
        cnt_ld     = 4'b0001;
        cyc("cnt_load", 4'b0000, 4'b0001, 14'd3);
        access(1'b1, 1'b0, 1'b0, SZ_W, 32'h8000_1000, 32'h0);
        cyc("cnt_1st", 4'b0000, 4'b0001, 14'd2);
        access(1'b1, 1'b0, 1'b0, SZ_W, 32'h8000_1000, 32'h0);
        cyc("cnt_2nd", 4'b0000, 4'b0001, 14'd1);
        access(1'b1, 1'b0, 1'b0, SZ_W, 32'h8000_1000, 32'h0);
        cyc("cnt_3rd", 4'b0001, 4'b0001, 14'd3);
        access(1'b1, 1'b0, 1'b0, SZ_W, 32'h8000_1000, 32'h0);
        cyc("cnt_dec", 4'b0000, 4'b0001, 14'd2);
        cnt_val[0] = 14'd5;
        cnt_ld     = 4'b0001;
        access(1'b1, 1'b0, 1'b0, SZ_W, 32'h8000_1000, 32'h0);
        cyc("ld_wins", 4'b0000, 4'b0001, 14'd5);

        // Killed accesses leave counters alone
        access(1'b1, 1'b0, 1'b0, SZ_W, 32'h8000_1000, 32'h0);
        flush = 1'b1;
        cyc("flush", 4'b0000, 4'b0001, 14'd5);
        access(1'b1, 1'b0, 1'b1, SZ_W, 32'h8000_1000, 32'h0);
        cyc("dma", 4'b0000, 4'b0001, 14'd5);
        access(1'b1, 1'b0, 1'b0, SZ_W, 32'h8000_1000, 32'h0);
        cyc("after_kill", 4'b0000, 4'b0001, 14'd4);

        // Global enable off
        for (int i = 0; i < NT; i++) cfg[i].m = 1'b0;
        access(1'b1, 1'b0, 1'b0, SZ_W, 32'h8000_1000, 32'h0);
        cyc("disabled", 4'b0000, 4'b0001, 14'd4);
        for (int i = 0; i < 3; i++) cfg[i].m = 1'b1;
        access(1'b1, 1'b0, 1'b0, SZ_W, 32'h8000_1000, 32'h0);
        cyc("pre_rst", 4'b0000, 4'b0001, 14'd3);

        // Reset with a would-be fire in flight
        access(1'b0, 1'b1, 1'b0, SZ_W, 32'h8000_1080, 32'h0);
        rst = 1'b1;
        cyc("rst_mid", 4'b0000, 4'b0000, 14'd0);

        // Even/odd pair chaining
        cnt_val = '0;
        cfg[0]  = mk_cfg(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0100);
        cfg[1]  = mk_cfg(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0055);
        access(1'b0, 1'b1, 1'b0, SZ_W, 32'h0000_0100, 32'h0000_0055);
        cyc("chain_both", 4'b0011, 4'b0011, 14'd0);
`ifdef MCU_EL2_LSU_TRIG_CHAIN_EN
        access(1'b0, 1'b1, 1'b0, SZ_W, 32'h0000_0100, 32'h0000_0056);
        cyc("chain_ch0_only", 4'b0000, 4'b0011, 14'd0);
        access(1'b0, 1'b1, 1'b0, SZ_W, 32'h0000_0104, 32'h0000_0055);
        cyc("chain_ch1_only", 4'b0000, 4'b0011, 14'd0);
`else
        access(1'b0, 1'b1, 1'b0, SZ_W, 32'h0000_0100, 32'h0000_0056);
        cyc("nochain_ch0_only", 4'b0001, 4'b0011, 14'd0);
        access(1'b0, 1'b1, 1'b0, SZ_W, 32'h0000_0104, 32'h0000_0055);
        cyc("nochain_ch1_only", 4'b0010, 4'b0011, 14'd0);
`endif
        cyc("final_idle", 4'b0000, 4'b0011, 14'd0);

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
